// File: rtl/cnn_frame_ctrl.sv
// cnn_frame_ctrl: gates one frame of ADC samples into the CNN pipeline, waits for its result, tracks tool wear
module cnn_frame_ctrl #(
  parameter int ADC_WIDTH      = 12,
  parameter int FRAME_SAMPLES  = 102400,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ALARM_COUNT    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic                 adc_valid_in,
  input  logic [ADC_WIDTH-1:0] adc_data_in,
  output logic                 cnn_valid_in,
  input  logic                 cnn_ready_in,
  output logic [ADC_WIDTH-1:0] cnn_data_in,
  input  logic                 cnn_result_valid,
  input  logic                 cnn_result,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 condition,
  output logic                 wear_alarm,
  output logic                 overrun,
  output logic                 timeout_err
);
  localparam int SW = $clog2(FRAME_SAMPLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int WW = $clog2(ALARM_COUNT) + 1;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RESULT, DONE} state_t;
  state_t state;
  logic [SW-1:0] sample_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [WW-1:0] wear_cnt, wear_nxt;
  logic streaming, accept;
  assign streaming    = state == STREAM;
  assign accept       = streaming && adc_valid_in && cnn_ready_in;
  assign cnn_valid_in = streaming && adc_valid_in;
  assign cnn_data_in  = streaming ? adc_data_in : '0;
  assign wear_nxt     = !cnn_result ? '0 :
                        wear_cnt >= WW'(ALARM_COUNT) ? wear_cnt : wear_cnt + 1'b1;
  // busy spans the whole frame including its DONE cycle, so it drops after frame_done
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      timeout_cnt <= '0;
      wear_cnt    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      condition   <= 1'b0;
      wear_alarm  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        sample_cnt  <= '0;
        timeout_cnt <= '0;
      end else
        case (state)
          IDLE:
            if (start) begin
              state       <= STREAM;
              busy        <= 1'b1;
              sample_cnt  <= '0;
              timeout_cnt <= '0;
              overrun     <= 1'b0;
              timeout_err <= 1'b0;
            end
          STREAM: begin
            if (adc_valid_in && !cnn_ready_in) overrun <= 1'b1;
            if (accept) begin
              sample_cnt <= sample_cnt + 1'b1;
              if (sample_cnt == SW'(FRAME_SAMPLES - 1)) state <= WAIT_RESULT;
            end
          end
          WAIT_RESULT:
            if (cnn_result_valid) begin
              state      <= DONE;
              frame_done <= 1'b1;
              condition  <= cnn_result;
              wear_cnt   <= wear_nxt;
              wear_alarm <= wear_nxt >= WW'(ALARM_COUNT);
            end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state       <= IDLE;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end else
              timeout_cnt <= timeout_cnt + 1'b1;
          DONE: begin
            state       <= continuous ? STREAM : IDLE;
            busy        <= continuous;
            sample_cnt  <= '0;
            timeout_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// tb_cnn_frame_ctrl: scoreboard bench; expected frame results are queued when a result is driven and checked on frame_done
module tb_cnn_frame_ctrl;
  localparam int AW = 12, FS = 8, TO = 16, AC = 2;
  logic clk = 0, rst = 0, start = 0, continuous = 0, abort = 0;
  logic adc_valid_in = 1, cnn_ready_in = 1, cnn_result_valid = 0, cnn_result = 0;
  logic [AW-1:0] adc_data_in = '0;
  logic cnn_valid_in, busy, frame_done, condition, wear_alarm, overrun, timeout_err;
  logic [AW-1:0] cnn_data_in;
  int vectors = 0, miscompares = 0, beats = 0, dones = 0, m_wear = 0, b = 0, d = 0;
  logic [1:0] exp_q[$];

  cnn_frame_ctrl #(.ADC_WIDTH(AW), .FRAME_SAMPLES(FS), .TIMEOUT_CYCLES(TO), .ALARM_COUNT(AC)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .adc_valid_in(adc_valid_in), .adc_data_in(adc_data_in), .cnn_valid_in(cnn_valid_in),
    .cnn_ready_in(cnn_ready_in), .cnn_data_in(cnn_data_in), .cnn_result_valid(cnn_result_valid),
    .cnn_result(cnn_result), .busy(busy), .frame_done(frame_done), .condition(condition),
    .wear_alarm(wear_alarm), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats < n && k < 100) begin
      tick;
      k++;
    end
    if (beats < n) check("beat_budget", beats, n);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (dones < n && k < 100) begin
      tick;
      k++;
    end
    if (dones < n) check("done_budget", dones, n);
  endtask

  task automatic send_result(input bit r);
    m_wear = r ? (m_wear < AC ? m_wear + 1 : AC) : 0;
    exp_q.push_back({r, m_wear >= AC});
    cnn_result = r;
    cnn_result_valid = 1;
    tick;
    cnn_result_valid = 0;
  endtask

  initial forever begin
    @(posedge clk);
    #1 adc_data_in = AW'($urandom);
  end

  always @(negedge clk) begin
    if (cnn_valid_in && cnn_ready_in) beats++;
    if (cnn_valid_in) check("pass_data", cnn_data_in, adc_data_in);
    if (!busy) check("idle_out", {cnn_valid_in, cnn_data_in}, 0);
    if (frame_done) begin
      dones++;
      if (exp_q.size() == 0) check("spurious_done", 1, 0);
      else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("condition", condition, e[1]);
        check("wear_alarm", wear_alarm, e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("reset_outs", {busy, frame_done, condition, wear_alarm, overrun, timeout_err, cnn_valid_in}, 0);
    check("reset_data", cnn_data_in, 0);
    #20 rst = 1;
    tick;
    // single shot
    pulse_start;
    check("t1_busy", busy, 1);
    wait_beats(8);
    check("t1_wait_valid", cnn_valid_in, 0);
    repeat (4) tick;
    send_result(0);
    check("t1_done", frame_done, 1);
    check("t1_busy_done", busy, 1);
    tick;
    check("t1_done_fall", frame_done, 0);
    check("t1_busy_fall", busy, 0);
    repeat (3) tick;
    check("t1_beats", beats, 8);
    check("t1_dones", dones, 1);
    // backpressure on offered samples 3 and 4
    b = beats;
    pulse_start;
    for (int i = 1; i <= 10; i++) begin
      cnn_ready_in = !(i == 3 || i == 4);
      if (i == 10) check("t2_still_stream", cnn_valid_in, 1);
      tick;
    end
    cnn_ready_in = 1;
    check("t2_beats", beats - b, 8);
    check("t2_wait", cnn_valid_in, 0);
    check("t2_overrun", overrun, 1);
    send_result(0);
    wait_done(2);
    // timeout
    b = beats;
    pulse_start;
    wait_beats(b + 8);
    repeat (15) tick;
    check("t3_err_early", timeout_err, 0);
    tick;
    check("t3_err", timeout_err, 1);
    check("t3_idle", busy, 0);
    repeat (3) tick;
    check("t3_dones", dones, 2);
    check("t3_sticky", timeout_err, 1);
    // continuous wear 1,1,0
    continuous = 1;
    b = beats;
    pulse_start;
    check("t4_err_clear", timeout_err, 0);
    for (int f = 0; f < 3; f++) begin
      if (f == 2) continuous = 0;
      wait_beats(b + 8 * (f + 1));
      repeat (2) tick;
      send_result(f != 2);
      check("t4_alarm", wear_alarm, f == 1);
      wait_done(3 + f);
      if (f < 2) check("t4_restream", cnn_valid_in, 1);
      else check("t4_stop", {busy, cnn_valid_in}, 0);
    end
    // abort mid-stream and abort beating start
    b = beats;
    d = dones;
    pulse_start;
    wait_beats(b + 4);
    abort = 1;
    tick;
    abort = 0;
    check("t5_valid", cnn_valid_in, 0);
    check("t5_busy", busy, 0);
    cnn_result = 1;
    cnn_result_valid = 1;
    tick;
    cnn_result_valid = 0;
    repeat (3) tick;
    check("t5_condition", condition, 0);
    check("t5_dones", dones, d);
    start = 1;
    abort = 1;
    tick;
    start = 0;
    abort = 0;
    check("t5_start_abort", busy, 0);
    // async reset mid-wait
    b = beats;
    pulse_start;
    wait_beats(b + 8);
    send_result(1);
    wait_done(d + 1);
    b = beats;
    pulse_start;
    cnn_ready_in = 0;
    tick;
    cnn_ready_in = 1;
    wait_beats(b + 8);
    repeat (3) tick;
    check("t6_pre", {busy, condition, overrun}, 3'b111);
    #3 rst = 0;
    m_wear = 0;
    #1;
    check("t6_reset_outs", {busy, frame_done, condition, wear_alarm, overrun, timeout_err, cnn_valid_in}, 0);
    check("t6_reset_data", cnn_data_in, 0);
    #2 rst = 1;
    tick;
    d = dones;
    b = beats;
    pulse_start;
    wait_beats(b + 8);
    check("t6_clean_overrun", overrun, 0);
    send_result(1);
    wait_done(d + 1);
    check("t6_done_once", dones, d + 1);
    check("t6_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
